// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the instruction fetch unit and its bench.
// Contents:
//   OPC_HALT              opcode that stops fetching once decode consumes it
//   OPC_MSB/LSB, FUNC_MSB/LSB  instruction field bit positions
//   fetch_state_t         fetch FSM states {RUN, HALTED}
//   fetch_entry_t         one buffered instruction: {pc, instr}
//   word_align()          clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [5:0] OPC_HALT = 6'b111111;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the fetch unit's three bus-facing groups:
//   imem_*      word read requests to instruction memory and in-order responses
//   if_*        instruction handshake towards decode plus decoded opcode/func
//   redirect_*  branch/jump restart requests from execute
//   halted      fetch permanently stopped (until reset)
// Modports:
//   master  the fetch unit
//   slave   the environment (memory, decode, execute)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [5:0]  instruction_opcode;
    logic [5:0]  func_code;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output if_valid, if_instr, if_pc, instruction_opcode, func_code,
        input  if_ready,
        input  redirect_valid, redirect_pc,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  if_valid, if_instr, if_pc, instruction_opcode, func_code,
        output if_ready,
        output redirect_valid, redirect_pc,
        input  halted
    );

endinterface

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous FIFO of fetched instructions ({pc, instr} entries).
// Flush has priority over push and pop. The caller guarantees no push when
// full and no pop when empty.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          drop the head entry
//   flush        discard all entries
//   head         entry at the head (valid when !empty)
//   count        number of stored entries
//   empty        count == 0
// -----------------------------------------------------------------------------
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(BUF_DEPTH):0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because BUF_DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the storage array has no reset; only pointers/count are reset,
    // and nothing is read out until count says an entry was written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, issues word reads to instruction memory, buffers returned words
// and presents them to decode on a valid/ready handshake. Execute can redirect
// the PC; consuming the halt opcode stops fetching until reset.
// Parameters:
//   RESET_PC   byte address fetched first after reset
//   BUF_DEPTH  buffer entries and cap on in-flight + buffered words (>=2, 2^n)
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          instr_fetch_unit_if.master (imem, decode and redirect groups)
//   perf_fetched instructions consumed by decode  (FETCH_PERF_CNT_EN only)
//   perf_stall   cycles decode was ready with nothing valid in RUN
//                                                  (FETCH_PERF_CNT_EN only)
// Build option: define FETCH_PERF_CNT_EN to add the two performance counters.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_fetch_unit_if.master       bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_stall
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    // Low during reset and the first cycle after it, so no request is raised
    // before the unit has seen one clean reset-free edge.
    logic             started;

    fetch_entry_t     buf_head;
    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;

    logic             in_run;
    logic             head_valid;
    logic             consume;
    logic             halt_consume;
    logic             redirect_take;
    logic [CNT_W:0]   in_use;
    logic             req;
    logic             issue;
    logic             resp_drop;
    logic             push;

    // NOTE: every always_comb output gets a default assignment first, so no
    // path through the block can leave a signal unassigned (no latches).
    always_comb begin
        in_run        = 1'b0;
        head_valid    = 1'b0;
        consume       = 1'b0;
        halt_consume  = 1'b0;
        redirect_take = 1'b0;
        in_use        = '0;
        req           = 1'b0;
        issue         = 1'b0;
        resp_drop     = 1'b0;
        push          = 1'b0;

        in_run       = (state == RUN);
        head_valid   = in_run && !buf_empty;
        consume      = head_valid && bus.if_ready;
        halt_consume = consume && (buf_head.instr[OPC_MSB:OPC_LSB] == OPC_HALT);
        // A halt consumed in the same cycle wins over a redirect.
        redirect_take = bus.redirect_valid && in_run && !halt_consume;

        // Credit rule: words in flight plus words buffered never exceed the
        // buffer depth, so every response has a slot waiting for it.
        in_use = {1'b0, outstanding} + {1'b0, buf_count};
        req    = in_run && started && !redirect_take &&
                 (in_use < (CNT_W+1)'(BUF_DEPTH));
        issue  = req && bus.imem_ready;

        // Responses belonging to a squashed fetch stream are discarded,
        // including one that arrives in the redirect cycle itself.
        resp_drop = bus.imem_rvalid && ((drop != '0) || redirect_take);
        push      = bus.imem_rvalid && !resp_drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            started     <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(bus.imem_rvalid);

            case (state)
                RUN:     if (halt_consume) state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase

            if (redirect_take) begin
                pc      <= word_align(bus.redirect_pc);
                resp_pc <= word_align(bus.redirect_pc);
                // Everything still in flight after this cycle's response is stale.
                drop    <= outstanding - CNT_W'(bus.imem_rvalid);
            end else begin
                if (issue) pc <= pc + 32'd4;
                if (bus.imem_rvalid) begin
                    if (drop != '0) drop    <= drop - 1'b1;
                    else            resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ('{pc: resp_pc, instr: bus.imem_rdata}),
        .pop       (consume),
        .flush     (redirect_take),
        .head      (buf_head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    assign bus.imem_req           = req;
    assign bus.imem_addr          = pc;
    assign bus.if_valid           = head_valid;
    assign bus.if_instr           = buf_head.instr;
    assign bus.if_pc              = buf_head.pc;
    assign bus.instruction_opcode = buf_head.instr[OPC_MSB:OPC_LSB];
    assign bus.func_code          = buf_head.instr[FUNC_MSB:FUNC_LSB];
    assign bus.halted             = (state == HALTED);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (consume) perf_fetched <= perf_fetched + 32'd1;
            if (in_run && bus.if_ready && !head_valid) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit: an in-order memory model with optional
// response hold, and a scoreboard of expected instruction addresses that is
// refilled whenever the bench redirects or resets the unit.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] HALT_ADDR = 32'h0000_0210;

    logic clk = 1'b0;
    logic reset;

    instr_fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int          checks     = 0;
    int          failures   = 0;
    int          n_consumed = 0;
    int          cyc        = 0;
    int          halt_cyc   = -1;
    logic        mem_hold   = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] pending[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_word;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == HALT_ADDR) return 32'hFC00_0000;
        return {6'h02, a[27:2]};
    endfunction

    // Memory: accepts every request, answers in order, minimum latency one.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            pending.delete();
        end else begin
            if (bus.imem_rvalid === 1'b1) void'(pending.pop_front());
            if (bus.imem_req && bus.imem_ready) pending.push_back(bus.imem_addr);
        end
        #1;
        if (!reset && !mem_hold && pending.size() > 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pending[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
    end

    // Scoreboard: every consumed instruction must match the next expected pc.
    always @(negedge clk) begin
        if (!reset && bus.if_valid && bus.if_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_pc", 64'(bus.if_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_pc   = exp_q.pop_front();
                exp_word = mem_word(exp_pc);
                check("if_pc",    64'(bus.if_pc),              64'(exp_pc));
                check("if_instr", 64'(bus.if_instr),           64'(exp_word));
                check("opcode",   64'(bus.instruction_opcode), 64'(exp_word[31:26]));
                check("func",     64'(bus.func_code),          64'(exp_word[5:0]));
                if (exp_word[31:26] == OPC_HALT) halt_cyc = cyc;
                n_consumed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic wait_consumed(input string tag, input int target, input int budget);
        int b;
        b = 0;
        while (n_consumed < target && b < budget) begin
            @(posedge clk);
            b++;
        end
        #1;
        check(tag, 64'(n_consumed >= target), 64'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target, input logic [31:0] expect_pc, input int n);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        @(negedge clk);
        check("req_in_redirect", 64'(bus.imem_req), 64'd0);
        tick();
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        n_consumed = 0;
        push_seq(expect_pc, n);
    endtask

    initial begin
        reset              = 1'b1;
        bus.imem_ready     = 1'b1;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req",    64'(bus.imem_req), 64'd0);
        check("rst_valid",  64'(bus.if_valid), 64'd0);
        check("rst_halted", 64'(bus.halted),   64'd0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        push_seq(32'h0, 64);
        @(negedge clk);
        check("post_rst_req",   64'(bus.imem_req), 64'd0);
        check("post_rst_valid", 64'(bus.if_valid), 64'd0);

        // Streaming from RESET_PC
        tick();
        bus.if_ready = 1'b1;
        wait_consumed("stream_16", 16, 200);

        // Decode back-pressure for 10 cycles
        bus.if_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_consumed", 64'(n_consumed), 64'd16);
        check("stall_valid",    64'(bus.if_valid), 64'd1);
        check("stall_req",      64'(bus.imem_req), 64'd0);
        check("stall_head_pc",  64'(bus.if_pc),    64'h40);
        tick();
        bus.if_ready = 1'b1;
        wait_consumed("resume_24", 24, 100);

        // Redirect with two responses in flight, one arriving in the redirect cycle
        @(negedge clk);
        mem_hold = 1'b1;
        repeat (8) @(negedge clk);
        check("inflight_valid", 64'(bus.if_valid), 64'd0);
        check("inflight_req",   64'(bus.imem_req), 64'd0);
        mem_hold = 1'b0;
        do_redirect(32'h0000_0101, 32'h0000_0100, 32);
        wait_consumed("redirect_6", 6, 100);

        // PC wrap past 32'hFFFF_FFFC
        do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 16);
        wait_consumed("wrap_6", 6, 100);

        // Halt opcode consumed
        halt_cyc = -1;
        do_redirect(32'h0000_0200, 32'h0000_0200, 5);
        begin
            int b;
            b = 0;
            @(negedge clk);
            while (!bus.halted && b < 100) begin
                @(negedge clk);
                b++;
            end
        end
        check("halt_seen",     64'(bus.halted), 64'd1);
        check("halt_latency",  64'(cyc),        64'(halt_cyc + 1));
        check("halt_consumed", 64'(n_consumed), 64'd5);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0040;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("halted_req",   64'(bus.imem_req), 64'd0);
            check("halted_valid", 64'(bus.if_valid), 64'd0);
            check("halted_hold",  64'(bus.halted),   64'd1);
        end

        // Reset leaves HALTED, then reset again with a full buffer
        tick();
        reset        = 1'b1;
        bus.if_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        n_consumed = 0;
        push_seq(32'h0, 16);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("refill_halted", 64'(bus.halted),   64'd0);
        check("refill_valid",  64'(bus.if_valid), 64'd1);
        check("refill_pc",     64'(bus.if_pc),    64'h0);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_req",    64'(bus.imem_req), 64'd0);
        check("midrst_valid",  64'(bus.if_valid), 64'd0);
        check("midrst_halted", 64'(bus.halted),   64'd0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        n_consumed = 0;
        push_seq(32'h0, 16);
        bus.if_ready = 1'b1;
        wait_consumed("restart_4", 4, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
